// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue controller and the ALU datapath:
// opcodes, one-hot ALU selects, CCR bit positions and the decode record.
package alu_pkg;

  localparam int DATA_W = 16;
  localparam int OPC_W  = 5;
  localparam int RA_W   = 3;
  localparam int OP_W   = 7;

  localparam logic [OPC_W-1:0] OPC_NOP  = 5'd0;
  localparam logic [OPC_W-1:0] OPC_SETC = 5'd1;
  localparam logic [OPC_W-1:0] OPC_CLRC = 5'd2;
  localparam logic [OPC_W-1:0] OPC_NOT  = 5'd3;
  localparam logic [OPC_W-1:0] OPC_ADD  = 5'd4;
  localparam logic [OPC_W-1:0] OPC_SUB  = 5'd5;
  localparam logic [OPC_W-1:0] OPC_AND  = 5'd6;
  localparam logic [OPC_W-1:0] OPC_OR   = 5'd7;
  localparam logic [OPC_W-1:0] OPC_SHR  = 5'd8;
  localparam logic [OPC_W-1:0] OPC_SHL  = 5'd9;
  localparam logic [OPC_W-1:0] OPC_JZ   = 5'd10;
  localparam logic [OPC_W-1:0] OPC_JN   = 5'd11;
  localparam logic [OPC_W-1:0] OPC_JC   = 5'd12;
  localparam logic [OPC_W-1:0] OPC_JMP  = 5'd13;

  localparam logic [OP_W-1:0] ALU_ADD = 7'b0000001;
  localparam logic [OP_W-1:0] ALU_SUB = 7'b0000010;
  localparam logic [OP_W-1:0] ALU_AND = 7'b0000100;
  localparam logic [OP_W-1:0] ALU_OR  = 7'b0001000;
  localparam logic [OP_W-1:0] ALU_NOT = 7'b0010000;
  localparam logic [OP_W-1:0] ALU_SHR = 7'b0100000;
  localparam logic [OP_W-1:0] ALU_SHL = 7'b1000000;

  localparam int CCR_Z = 0;
  localparam int CCR_C = 1;
  localparam int CCR_N = 2;

  typedef enum logic [1:0] {
    COND_Z      = 2'd0,
    COND_N      = 2'd1,
    COND_C      = 2'd2,
    COND_ALWAYS = 2'd3
  } jcond_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

  typedef struct packed {
    logic [OP_W-1:0] alu_op;
    logic            alu_b_sel;
    logic            wb_en;
    logic            updates_c;
    logic            set_c;
    logic            clr_c;
    logic            is_jump;
    jcond_e          jump_cond;
    logic            illegal;
  } dec_t;

endpackage

// File: rtl/alu_op_decoder.sv
// Purely combinational opcode decode into ALU select, operand select,
// writeback/flag intent and jump condition.
module alu_op_decoder
  import alu_pkg::*;
(
  input  logic [OPC_W-1:0] opc_i,
  output dec_t             dec_o
);

  always_comb begin
    dec_o = '0;
    case (opc_i)
      OPC_NOP:  ;
      OPC_SETC: dec_o.set_c = 1'b1;
      OPC_CLRC: dec_o.clr_c = 1'b1;
      OPC_NOT: begin
        dec_o.alu_op = ALU_NOT;
        dec_o.wb_en  = 1'b1;
      end
      OPC_ADD: begin
        dec_o.alu_op    = ALU_ADD;
        dec_o.wb_en     = 1'b1;
        dec_o.updates_c = 1'b1;
      end
      OPC_SUB: begin
        dec_o.alu_op    = ALU_SUB;
        dec_o.wb_en     = 1'b1;
        dec_o.updates_c = 1'b1;
      end
      OPC_AND: begin
        dec_o.alu_op = ALU_AND;
        dec_o.wb_en  = 1'b1;
      end
      OPC_OR: begin
        dec_o.alu_op = ALU_OR;
        dec_o.wb_en  = 1'b1;
      end
      // Shift amount comes from the 5-bit immediate field.
      OPC_SHR: begin
        dec_o.alu_op    = ALU_SHR;
        dec_o.alu_b_sel = 1'b1;
        dec_o.wb_en     = 1'b1;
        dec_o.updates_c = 1'b1;
      end
      OPC_SHL: begin
        dec_o.alu_op    = ALU_SHL;
        dec_o.alu_b_sel = 1'b1;
        dec_o.wb_en     = 1'b1;
        dec_o.updates_c = 1'b1;
      end
      OPC_JZ: begin
        dec_o.is_jump   = 1'b1;
        dec_o.jump_cond = COND_Z;
      end
      OPC_JN: begin
        dec_o.is_jump   = 1'b1;
        dec_o.jump_cond = COND_N;
      end
      OPC_JC: begin
        dec_o.is_jump   = 1'b1;
        dec_o.jump_cond = COND_C;
      end
      OPC_JMP: begin
        dec_o.is_jump   = 1'b1;
        dec_o.jump_cond = COND_ALWAYS;
      end
      default: dec_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Two-state issue sequencer for the 16-bit ALU: captures one instruction,
// drives the datapath for one EXEC cycle, and maintains the {N,C,Z} CCR.
module alu_issue_ctrl
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [DATA_W-1:0] instr,
  input  logic              flush,
  output logic [OP_W-1:0]   alu_op,
  output logic              alu_b_sel,
  output logic [DATA_W-1:0] imm_out,
  output logic [RA_W-1:0]   rdst_addr,
  output logic [RA_W-1:0]   rsrc_addr,
  input  logic              zero_flag,
  input  logic              carry_flag,
  input  logic              negative_flag,
  output logic              wb_en,
  output logic [2:0]        ccr,
  output logic              branch_taken,
  output logic [RA_W-1:0]   branch_reg,
  output logic              illegal_op
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [2:0]        ccr_q, ccr_d;
  dec_t              dec;

  alu_op_decoder u_dec (
    .opc_i (instr_q[15:11]),
    .dec_o (dec)
  );

  assign instr_ready = (state_q == ST_IDLE);
  assign ccr         = ccr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
      ccr_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      ccr_q   <= ccr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    ccr_d        = ccr_q;
    alu_op       = '0;
    alu_b_sel    = 1'b0;
    imm_out      = '0;
    rdst_addr    = '0;
    rsrc_addr    = '0;
    wb_en        = 1'b0;
    branch_taken = 1'b0;
    branch_reg   = '0;
    illegal_op   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid && !flush) begin
          instr_d = instr;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d   = ST_IDLE;
        rdst_addr = instr_q[10:8];
        rsrc_addr = instr_q[7:5];
        imm_out   = {{(DATA_W-5){1'b0}}, instr_q[4:0]};
        alu_b_sel = dec.alu_b_sel;
        // A flushed EXEC leaves no architectural trace: no writeback, flags or branch.
        if (!flush) begin
          alu_op     = dec.alu_op;
          wb_en      = dec.wb_en;
          illegal_op = dec.illegal;
          if (dec.alu_op != '0) begin
            ccr_d[CCR_Z] = zero_flag;
            ccr_d[CCR_N] = negative_flag;
            if (dec.updates_c) ccr_d[CCR_C] = carry_flag;
          end
          if (dec.set_c) ccr_d[CCR_C] = 1'b1;
          if (dec.clr_c) ccr_d[CCR_C] = 1'b0;
          if (dec.is_jump) begin
            case (dec.jump_cond)
              COND_Z: if (ccr_q[CCR_Z]) begin
                branch_taken = 1'b1;
                ccr_d[CCR_Z] = 1'b0;
              end
              COND_N: if (ccr_q[CCR_N]) begin
                branch_taken = 1'b1;
                ccr_d[CCR_N] = 1'b0;
              end
              COND_C: if (ccr_q[CCR_C]) begin
                branch_taken = 1'b1;
                ccr_d[CCR_C] = 1'b0;
              end
              COND_ALWAYS: branch_taken = 1'b1;
            endcase
            if (branch_taken) branch_reg = instr_q[10:8];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: vector table through a scoreboard
// queue, plus hand-written flush, hold and reset sequences.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic        flush;
  logic [6:0]  alu_op;
  logic        alu_b_sel;
  logic [15:0] imm_out;
  logic [2:0]  rdst_addr;
  logic [2:0]  rsrc_addr;
  logic        zero_flag;
  logic        carry_flag;
  logic        negative_flag;
  logic        wb_en;
  logic [2:0]  ccr;
  logic        branch_taken;
  logic [2:0]  branch_reg;
  logic        illegal_op;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .flush         (flush),
    .alu_op        (alu_op),
    .alu_b_sel     (alu_b_sel),
    .imm_out       (imm_out),
    .rdst_addr     (rdst_addr),
    .rsrc_addr     (rsrc_addr),
    .zero_flag     (zero_flag),
    .carry_flag    (carry_flag),
    .negative_flag (negative_flag),
    .wb_en         (wb_en),
    .ccr           (ccr),
    .branch_taken  (branch_taken),
    .branch_reg    (branch_reg),
    .illegal_op    (illegal_op)
  );

  typedef struct {
    logic [15:0] instr;
    logic        z, c, n;
    logic [6:0]  op;
    logic        bsel;
    logic [15:0] imm;
    logic [2:0]  rd, rs;
    logic        wb, br;
    logic [2:0]  breg;
    logic        ill;
    logic [2:0]  ccr;
  } vec_t;

  vec_t tbl[17];
  vec_t sb[$];

  function automatic vec_t mk(input logic [15:0] i, input logic z, input logic c, input logic n,
                              input logic [6:0] op, input logic bsel, input logic [15:0] imm,
                              input logic [2:0] rd, input logic [2:0] rs, input logic wb,
                              input logic br, input logic [2:0] breg, input logic ill,
                              input logic [2:0] cc);
    vec_t v;
    v.instr = i; v.z = z; v.c = c; v.n = n; v.op = op; v.bsel = bsel; v.imm = imm;
    v.rd = rd; v.rs = rs; v.wb = wb; v.br = br; v.breg = breg; v.ill = ill; v.ccr = cc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Drive one instruction, compare EXEC outputs against the scoreboard head,
  // then compare the CCR after the EXEC-ending edge.
  task automatic run_vec(input string tag, input vec_t v);
    vec_t e;
    int   n;
    @(negedge clk);
    instr = v.instr; instr_valid = 1'b1;
    zero_flag = v.z; carry_flag = v.c; negative_flag = v.n;
    sb.push_back(v);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (instr_ready && n < 4);
    instr_valid = 1'b0;
    if (instr_ready) chk({tag, "_accept_timeout"}, 0, 1);
    @(negedge clk);
    e = sb.pop_front();
    chk({tag, "_alu_op"}, alu_op, e.op);
    chk({tag, "_b_sel"}, alu_b_sel, e.bsel);
    chk({tag, "_imm"}, imm_out, e.imm);
    chk({tag, "_rdst"}, rdst_addr, e.rd);
    chk({tag, "_rsrc"}, rsrc_addr, e.rs);
    chk({tag, "_wb_en"}, wb_en, e.wb);
    chk({tag, "_branch"}, branch_taken, e.br);
    chk({tag, "_branch_reg"}, branch_reg, e.breg);
    chk({tag, "_illegal"}, illegal_op, e.ill);
    @(posedge clk); #1;
    chk({tag, "_ccr"}, ccr, e.ccr);
    chk({tag, "_ready_back"}, instr_ready, 1);
    chk({tag, "_alu_op_idle"}, alu_op, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(16'h2140, 1,1,0, 7'b0000001, 0, 16'h0000, 1, 2, 1, 0, 0, 0, 3'b011);
    tbl[1]  = mk(16'h3380, 0,0,1, 7'b0000100, 0, 16'h0000, 3, 4, 1, 0, 0, 0, 3'b110);
    tbl[2]  = mk(16'h4B05, 0,0,0, 7'b1000000, 1, 16'h0005, 3, 0, 1, 0, 0, 0, 3'b000);
    tbl[3]  = mk(16'h0800, 1,0,1, 7'b0000000, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 3'b010);
    tbl[4]  = mk(16'h6500, 1,1,1, 7'b0000000, 0, 16'h0000, 5, 0, 0, 1, 5, 0, 3'b000);
    tbl[5]  = mk(16'h6500, 1,1,1, 7'b0000000, 0, 16'h0000, 5, 0, 0, 0, 0, 0, 3'b000);
    tbl[6]  = mk(16'h2EE0, 1,0,0, 7'b0000010, 0, 16'h0000, 6, 7, 1, 0, 0, 0, 3'b001);
    tbl[7]  = mk(16'h5400, 0,0,0, 7'b0000000, 0, 16'h0000, 4, 0, 0, 1, 4, 0, 3'b000);
    tbl[8]  = mk(16'h5400, 0,0,0, 7'b0000000, 0, 16'h0000, 4, 0, 0, 0, 0, 0, 3'b000);
    tbl[9]  = mk(16'h1A00, 0,1,1, 7'b0010000, 0, 16'h0000, 2, 0, 1, 0, 0, 0, 3'b100);
    tbl[10] = mk(16'h5900, 0,0,0, 7'b0000000, 0, 16'h0000, 1, 0, 0, 1, 1, 0, 3'b000);
    tbl[11] = mk(16'h3F15, 1,1,1, 7'b0001000, 0, 16'h0015, 7, 0, 1, 0, 0, 0, 3'b101);
    tbl[12] = mk(16'h6E00, 0,0,0, 7'b0000000, 0, 16'h0000, 6, 0, 0, 1, 6, 0, 3'b101);
    tbl[13] = mk(16'h4001, 0,1,0, 7'b0100000, 1, 16'h0001, 0, 0, 1, 0, 0, 0, 3'b010);
    tbl[14] = mk(16'hF800, 1,1,1, 7'b0000000, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 3'b010);
    tbl[15] = mk(16'h7000, 1,1,1, 7'b0000000, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 3'b010);
    tbl[16] = mk(16'h1000, 1,1,1, 7'b0000000, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 3'b000);

    rst_n = 1'b0; instr_valid = 1'b0; instr = '0; flush = 1'b0;
    zero_flag = 1'b0; carry_flag = 1'b0; negative_flag = 1'b0;
    #12;
    chk("rst_ready", instr_ready, 1);
    chk("rst_ccr", ccr, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_wb_en", wb_en, 0);
    chk("rst_branch", branch_taken, 0);
    chk("rst_illegal", illegal_op, 0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 17; i++) run_vec($sformatf("v%0d", i), tbl[i]);

    // Flush during EXEC of ADD: nothing committed, back to IDLE.
    @(negedge clk);
    instr = 16'h2140; instr_valid = 1'b1;
    zero_flag = 1'b1; carry_flag = 1'b1; negative_flag = 1'b1;
    @(posedge clk); #1;
    chk("flush_accept", instr_ready, 0);
    instr_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    chk("flush_alu_op", alu_op, 0);
    chk("flush_wb_en", wb_en, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_ready", instr_ready, 1);
    chk("flush_ccr", ccr, 0);

    // Flush in IDLE blocks capture.
    @(negedge clk);
    instr = 16'h2140; instr_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    chk("idle_flush_no_capture", instr_ready, 1);
    @(negedge clk);
    chk("idle_flush_wb_en", wb_en, 0);
    instr_valid = 1'b0; flush = 1'b0;

    // instr_valid held through EXEC with a different word: ignored.
    @(negedge clk);
    instr = 16'h2140; instr_valid = 1'b1;
    zero_flag = 1'b0; carry_flag = 1'b0; negative_flag = 1'b0;
    @(posedge clk); #1;
    chk("hold_accept", instr_ready, 0);
    instr = 16'hF800;
    @(negedge clk);
    chk("hold_alu_op", alu_op, 7'b0000001);
    chk("hold_illegal", illegal_op, 0);
    @(posedge clk); #1;
    chk("hold_idle_gap", instr_ready, 1);
    instr_valid = 1'b0;

    // Reset asserted mid-EXEC of ADD.
    run_vec("pre_rst", mk(16'h2140, 1,1,0, 7'b0000001, 0, 16'h0000, 1, 2, 1, 0, 0, 0, 3'b011));
    @(negedge clk);
    instr = 16'h2140; instr_valid = 1'b1;
    zero_flag = 1'b0; carry_flag = 1'b0; negative_flag = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_wb_before", wb_en, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_wb_en", wb_en, 0);
    chk("rst_mid_alu_op", alu_op, 0);
    chk("rst_mid_ccr", ccr, 0);
    chk("rst_mid_ready", instr_ready, 1);
    chk("rst_mid_rdst", rdst_addr, 0);
    @(posedge clk); #1;
    chk("rst_mid_ccr_held", ccr, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_idle", instr_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
